// File: rtl/bitmap_vga_renderer_if.sv
// Bitmap ROM bus: row address out to a synchronous ROM, row data back one clock later.
interface bitmap_vga_renderer_if #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned IMG_W  = 256
) ();
   logic [ADDR_W-1:0] rom_addr;
   logic [IMG_W-1:0]  rom_data;

   modport master (output rom_addr, input rom_data);
   modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/bitmap_vga_renderer.sv
// VGA timing generator with a 3-stage bitmap fetch/render pipeline: positions and scales one
// ROM bitmap on screen, drives fg/bg colours, and optionally blinks the foreground per frame.
module bitmap_vga_renderer #(
   parameter int unsigned H_ACTIVE     = 800,
   parameter int unsigned H_FP         = 40,
   parameter int unsigned H_SYNC       = 128,
   parameter int unsigned H_BP         = 88,
   parameter int unsigned V_ACTIVE     = 600,
   parameter int unsigned V_FP         = 1,
   parameter int unsigned V_SYNC       = 4,
   parameter int unsigned V_BP         = 23,
   parameter bit          SYNC_POL     = 1'b1,
   parameter int unsigned IMG_W        = 256,
   parameter int unsigned IMG_H        = 64,
   parameter int unsigned ADDR_W       = 11,
   parameter int unsigned SCALE_LOG2   = 0,
   parameter int unsigned COLOR_W      = 1,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic                  CLK_40M,
   input  logic                  RSTn,
   input  logic                  enable,
   input  logic [10:0]           img_x,
   input  logic [10:0]           img_y,
   input  logic [3*COLOR_W-1:0]  fg_rgb,
   input  logic [3*COLOR_W-1:0]  bg_rgb,
   input  logic                  blink_en,
   bitmap_vga_renderer_if.master rom,
   output logic                  Hsync_sig,
   output logic                  Vsync_sig,
   output logic [COLOR_W-1:0]    Vga_red,
   output logic [COLOR_W-1:0]    Vga_green,
   output logic [COLOR_W-1:0]    Vga_blue,
   output logic                  frame_start,
   output logic                  blink_phase
);

   localparam int unsigned H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW     = $clog2(H_TOT);
   localparam int unsigned VW     = $clog2(V_TOT);
   localparam int unsigned WIN_W  = 12;
   localparam int unsigned CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned FW     = $clog2(BLINK_FRAMES + 1);
   localparam int unsigned RGB_W  = 3 * COLOR_W;
   localparam int unsigned IMG_WS = IMG_W << SCALE_LOG2;
   localparam int unsigned IMG_HS = IMG_H << SCALE_LOG2;
   localparam bit          SYNC_OFF = ~SYNC_POL;

   logic [HW-1:0]     h_cnt;
   logic [VW-1:0]     v_cnt;
   logic [FW-1:0]     f_cnt;
   logic [10:0]       x_sh, y_sh;
   logic              h_last_c, v_last_c, frame_wrap_c, at_origin_c;
   logic [WIN_W-1:0]  h_w, v_w, x_w, y_w;
   logic              in_x_c, in_y_c, active_c, hs_c, vs_c;
   logic [CW-1:0]     col_c;
   logic [ADDR_W-1:0] row_c;

   logic [CW-1:0]     col_s1, col_s2;
   logic              in_x_s1, in_y_s1, act_s1, hs_s1, vs_s1, fs_s1;
   logic              in_x_s2, in_y_s2, act_s2, hs_s2, vs_s2, fs_s2;
   logic [CW-1:0]     bit_idx_c;
   logic              pix_c;
   logic [RGB_W-1:0]  rgb_c;

   assign h_last_c     = (h_cnt == HW'(H_TOT - 1));
   assign v_last_c     = (v_cnt == VW'(V_TOT - 1));
   assign frame_wrap_c = h_last_c && v_last_c;
   assign at_origin_c  = (h_cnt == '0) && (v_cnt == '0);

   // Raster counters
   always_ff @(posedge CLK_40M or negedge RSTn) begin
      if (!RSTn) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last_c) begin
         h_cnt <= '0;
         v_cnt <= v_last_c ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   // Position shadow; the live inputs are used on the origin clock so line 0 sees the new value
   always_ff @(posedge CLK_40M or negedge RSTn) begin
      if (!RSTn) begin
         x_sh <= '0;
         y_sh <= '0;
      end else if (at_origin_c) begin
         x_sh <= img_x;
         y_sh <= img_y;
      end
   end

   assign h_w = WIN_W'(h_cnt);
   assign v_w = WIN_W'(v_cnt);
   assign x_w = WIN_W'(at_origin_c ? img_x : x_sh);
   assign y_w = WIN_W'(at_origin_c ? img_y : y_sh);

   assign in_x_c   = (h_w >= x_w) && (h_w < x_w + WIN_W'(IMG_WS)) && (h_w < WIN_W'(H_ACTIVE));
   assign in_y_c   = (v_w >= y_w) && (v_w < y_w + WIN_W'(IMG_HS)) && (v_w < WIN_W'(V_ACTIVE));
   assign active_c = (h_w < WIN_W'(H_ACTIVE)) && (v_w < WIN_W'(V_ACTIVE));
   assign hs_c     = ((h_w >= WIN_W'(H_ACTIVE + H_FP)) &&
                      (h_w <  WIN_W'(H_ACTIVE + H_FP + H_SYNC))) ? SYNC_POL : SYNC_OFF;
   assign vs_c     = ((v_w >= WIN_W'(V_ACTIVE + V_FP)) &&
                      (v_w <  WIN_W'(V_ACTIVE + V_FP + V_SYNC))) ? SYNC_POL : SYNC_OFF;
   assign col_c    = CW'((h_w - x_w) >> SCALE_LOG2);
   assign row_c    = ADDR_W'((v_w - y_w) >> SCALE_LOG2);

   // Stage 1: ROM row request plus column and flags
   always_ff @(posedge CLK_40M or negedge RSTn) begin
      if (!RSTn) begin
         rom.rom_addr <= '0;
         col_s1       <= '0;
         in_x_s1      <= 1'b0;
         in_y_s1      <= 1'b0;
         act_s1       <= 1'b0;
         hs_s1        <= SYNC_OFF;
         vs_s1        <= SYNC_OFF;
         fs_s1        <= 1'b0;
      end else begin
         if (in_y_c) rom.rom_addr <= row_c;
         col_s1  <= col_c;
         in_x_s1 <= in_x_c;
         in_y_s1 <= in_y_c;
         act_s1  <= active_c;
         hs_s1   <= hs_c;
         vs_s1   <= vs_c;
         fs_s1   <= at_origin_c;
      end
   end

   // Stage 2: wait for the ROM row
   always_ff @(posedge CLK_40M or negedge RSTn) begin
      if (!RSTn) begin
         col_s2  <= '0;
         in_x_s2 <= 1'b0;
         in_y_s2 <= 1'b0;
         act_s2  <= 1'b0;
         hs_s2   <= SYNC_OFF;
         vs_s2   <= SYNC_OFF;
         fs_s2   <= 1'b0;
      end else begin
         col_s2  <= col_s1;
         in_x_s2 <= in_x_s1;
         in_y_s2 <= in_y_s1;
         act_s2  <= act_s1;
         hs_s2   <= hs_s1;
         vs_s2   <= vs_s1;
         fs_s2   <= fs_s1;
      end
   end

   // MSB of the row is the leftmost pixel
   assign bit_idx_c = CW'(IMG_W - 1) - col_s2;
   assign pix_c     = rom.rom_data[bit_idx_c];

   always_comb begin
      rgb_c = '0;
      if (act_s2 && enable) begin
         if (in_x_s2 && in_y_s2 && pix_c && !(blink_en && blink_phase)) rgb_c = fg_rgb;
         else                                                          rgb_c = bg_rgb;
      end
   end

   // Stage 3: pin registers
   always_ff @(posedge CLK_40M or negedge RSTn) begin
      if (!RSTn) begin
         Vga_red     <= '0;
         Vga_green   <= '0;
         Vga_blue    <= '0;
         Hsync_sig   <= SYNC_OFF;
         Vsync_sig   <= SYNC_OFF;
         frame_start <= 1'b0;
      end else begin
         Vga_red     <= rgb_c[RGB_W-1 -: COLOR_W];
         Vga_green   <= rgb_c[2*COLOR_W-1 -: COLOR_W];
         Vga_blue    <= rgb_c[COLOR_W-1:0];
         Hsync_sig   <= hs_s2;
         Vsync_sig   <= vs_s2;
         frame_start <= fs_s2;
      end
   end

   // Blink half-period counter, advanced on every frame wrap
   always_ff @(posedge CLK_40M or negedge RSTn) begin
      if (!RSTn) begin
         f_cnt       <= '0;
         blink_phase <= 1'b0;
      end else if (frame_wrap_c) begin
         if (f_cnt == FW'(BLINK_FRAMES - 1)) begin
            f_cnt       <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            f_cnt <= f_cnt + FW'(1);
         end
      end
   end

endmodule

// File: tb/tb_bitmap_vga_renderer.sv
// Scoreboard bench: two renderers (scale 1x with active-high sync, 2x with active-low sync)
// on a shrunken raster, checked cycle by cycle against a raster-level reference model.
module tb_bitmap_vga_renderer;

   localparam int HA = 40, HFP = 2, HSY = 4, HBP = 3;
   localparam int VA = 20, VFP = 1, VSY = 2, VBP = 2;
   localparam int H_TOT = HA + HFP + HSY + HBP;
   localparam int V_TOT = VA + VFP + VSY + VBP;
   localparam int FRAME = H_TOT * V_TOT;
   localparam int IW = 16, IH = 8, AW = 4, CWD = 2, BF = 2;

   typedef struct packed {
      logic            hs;
      logic            vs;
      logic            fs;
      logic [3*CWD-1:0] rgb;
   } pins_t;

   typedef struct packed {
      pins_t p0;
      pins_t p1;
   } pin_pair_t;

   typedef struct packed {
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic          ph;
   } st_t;

   localparam pins_t IDLE0 = '{hs: 1'b0, vs: 1'b0, fs: 1'b0, rgb: '0};
   localparam pins_t IDLE1 = '{hs: 1'b1, vs: 1'b1, fs: 1'b0, rgb: '0};

   logic clk = 1'b0;
   logic rst_n;
   logic enable, blink_en;
   logic [10:0] img_x, img_y;
   logic [3*CWD-1:0] fg, bg;

   logic hs0, vs0, fs0, bp0, hs1, vs1, fs1, bp1;
   logic [CWD-1:0] r0, g0, b0, r1, g1, b1;
   pins_t act0, act1;

   logic [IW-1:0] rom [16];

   bitmap_vga_renderer_if #(.ADDR_W(AW), .IMG_W(IW)) rif0 ();
   bitmap_vga_renderer_if #(.ADDR_W(AW), .IMG_W(IW)) rif1 ();

   always #5 clk = ~clk;

   bitmap_vga_renderer #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .SYNC_POL(1'b1), .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW),
      .SCALE_LOG2(0), .COLOR_W(CWD), .BLINK_FRAMES(BF)
   ) dut0 (
      .CLK_40M(clk), .RSTn(rst_n), .enable(enable), .img_x(img_x), .img_y(img_y),
      .fg_rgb(fg), .bg_rgb(bg), .blink_en(blink_en), .rom(rif0),
      .Hsync_sig(hs0), .Vsync_sig(vs0), .Vga_red(r0), .Vga_green(g0), .Vga_blue(b0),
      .frame_start(fs0), .blink_phase(bp0)
   );

   bitmap_vga_renderer #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .SYNC_POL(1'b0), .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW),
      .SCALE_LOG2(1), .COLOR_W(CWD), .BLINK_FRAMES(BF)
   ) dut1 (
      .CLK_40M(clk), .RSTn(rst_n), .enable(enable), .img_x(img_x), .img_y(img_y),
      .fg_rgb(fg), .bg_rgb(bg), .blink_en(blink_en), .rom(rif1),
      .Hsync_sig(hs1), .Vsync_sig(vs1), .Vga_red(r1), .Vga_green(g1), .Vga_blue(b1),
      .frame_start(fs1), .blink_phase(bp1)
   );

   // Synchronous ROMs: data follows the address by one clock
   always @(posedge clk) begin
      rif0.rom_data <= rom[rif0.rom_addr];
      rif1.rom_data <= rom[rif1.rom_addr];
   end

   assign act0 = {hs0, vs0, fs0, r0, g0, b0};
   assign act1 = {hs1, vs1, fs1, r1, g1, b1};

   int n_chk = 0;
   int n_pass = 0;

   function automatic void chk(input string nm, input int e, input logic [31:0] act,
                               input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at edge %0d: got %h expected %h", nm, e, act, exp);
   endfunction

   // Reference model state
   int          e_cnt;
   int          m_x, m_y;
   int          m_addr [2];
   pin_pair_t   pin_q [$];
   st_t         st_q [$];

   function automatic pins_t exp_pin(input int h, input int v, input int s, input bit sp,
                                     input int fi);
      pins_t p;
      bit    on;
      int    col, row;
      p.hs  = (h >= HA + HFP && h < HA + HFP + HSY) ? sp : !sp;
      p.vs  = (v >= VA + VFP && v < VA + VFP + VSY) ? sp : !sp;
      p.fs  = (h == 0 && v == 0);
      p.rgb = '0;
      if (h < HA && v < VA && enable) begin
         on = 1'b0;
         if (h >= m_x && h < m_x + (IW << s) && v >= m_y && v < m_y + (IH << s)) begin
            col = (h - m_x) >> s;
            row = (v - m_y) >> s;
            on  = rom[row][IW-1-col];
         end
         p.rgb = (on && !(blink_en && ((fi / BF) % 2 == 1))) ? fg : bg;
      end
      return p;
   endfunction

   task automatic model_step(input int e);
      int        h, v, fi;
      pin_pair_t pp;
      st_t       st;
      h  = e % H_TOT;
      v  = (e / H_TOT) % V_TOT;
      fi = e / FRAME;
      if (h == 0 && v == 0) begin
         m_x = int'(img_x);
         m_y = int'(img_y);
      end
      for (int s = 0; s < 2; s++)
         if (v >= m_y && v < m_y + (IH << s) && v < VA) m_addr[s] = (v - m_y) >> s;
      pp.p0 = exp_pin(h, v, 0, 1'b1, fi);
      pp.p1 = exp_pin(h, v, 1, 1'b0, fi);
      st.a0 = AW'(m_addr[0]);
      st.a1 = AW'(m_addr[1]);
      st.ph = (((e + 1) / FRAME / BF) % 2) == 1;
      pin_q.push_back(pp);
      st_q.push_back(st);
   endtask

   // Producer: one expected entry per raster position
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pin_q.delete();
         st_q.delete();
         e_cnt = 0;
         m_addr[0] = 0;
         m_addr[1] = 0;
      end else begin
         model_step(e_cnt);
         e_cnt++;
      end
   end

   // Monitor: pins lag the raster position by 3 clocks, rom_addr by 1
   st_t       mon_st;
   pin_pair_t mon_pp;
   always @(negedge clk) begin
      if (rst_n && st_q.size() > 0) begin
         mon_st = st_q.pop_front();
         chk("rom_addr0", e_cnt, 32'(rif0.rom_addr), 32'(mon_st.a0));
         chk("rom_addr1", e_cnt, 32'(rif1.rom_addr), 32'(mon_st.a1));
         chk("blink_phase0", e_cnt, 32'(bp0), 32'(mon_st.ph));
         chk("blink_phase1", e_cnt, 32'(bp1), 32'(mon_st.ph));
         if (pin_q.size() >= 3) begin
            mon_pp = pin_q.pop_front();
            chk("pins0", e_cnt, 32'(act0), 32'(mon_pp.p0));
            chk("pins1", e_cnt, 32'(act1), 32'(mon_pp.p1));
         end else begin
            chk("fill0", e_cnt, 32'(act0), 32'(IDLE0));
            chk("fill1", e_cnt, 32'(act1), 32'(IDLE1));
         end
      end
   end

   task automatic goto(input int f, input int line);
      int target;
      target = f * FRAME + line * H_TOT;
      while (e_cnt < target) @(negedge clk);
   endtask

   task automatic new_look();
      img_x = 11'($urandom_range(45, 0));
      img_y = 11'($urandom_range(22, 0));
      fg    = 6'($urandom);
      bg    = 6'($urandom);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = IW'($urandom);
      rom[0]   = 16'h8001;
      rst_n    = 1'b0;
      enable   = 1'b1;
      blink_en = 1'b0;
      img_x    = 11'd5;
      img_y    = 11'd3;
      fg       = 6'h3F;
      bg       = 6'h00;
      repeat (3) @(negedge clk);
      chk("reset_pins0", -1, 32'(act0), 32'(IDLE0));
      chk("reset_pins1", -1, 32'(act1), 32'(IDLE1));
      rst_n = 1'b1;

      goto(0, VA);
      img_x = 11'd30; img_y = 11'd10; fg = 6'($urandom); bg = 6'($urandom);
      goto(1, VA);
      img_x = 11'd0;  img_y = 11'd0;
      goto(3, 10);
      img_x = 11'd20; img_y = 11'd4;
      goto(4, VA);
      enable = 1'b0;
      goto(5, VA);
      enable = 1'b1; blink_en = 1'b1;
      for (int f = 6; f < 12; f++) begin
         goto(f, VA);
         new_look();
      end

      // Asynchronous reset in the middle of an active line
      goto(12, 6);
      repeat (12) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_pins0", e_cnt, 32'(act0), 32'(IDLE0));
      chk("midrst_pins1", e_cnt, 32'(act1), 32'(IDLE1));
      chk("midrst_addr0", e_cnt, 32'(rif0.rom_addr), 32'd0);
      chk("midrst_addr1", e_cnt, 32'(rif1.rom_addr), 32'd0);
      chk("midrst_phase0", e_cnt, 32'(bp0), 32'd0);
      chk("midrst_phase1", e_cnt, 32'(bp1), 32'd0);
      repeat (3) @(negedge clk);
      img_x = 11'd35; img_y = 11'd15; fg = 6'($urandom); bg = 6'($urandom);
      rst_n = 1'b1;

      goto(4, 0);
      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bitmap_vga_renderer.md
Name: bitmap_vga_renderer

Overview:
- Parametrised successor to the single-screen VGA image display used for end-of-game screens.
- Combines a configurable VGA timing generator with a pipelined bitmap fetch/render path.
- Positions and scales one ROM bitmap anywhere on screen and drives programmable foreground/background colours of configurable depth.
- Adds optional frame-synchronous blinking. Sits between the external synchronous bitmap ROM and the VGA pins.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch, clocks
- H_SYNC, 128, horizontal sync width, clocks
- H_BP, 88, horizontal back porch, clocks
- V_ACTIVE, 600, visible lines
- V_FP, 1, vertical front porch, lines
- V_SYNC, 4, vertical sync width, lines
- V_BP, 23, vertical back porch, lines
- SYNC_POL, 1, asserted level of Hsync_sig/Vsync_sig
- IMG_W, 256, bitmap width in pixels; equals ROM word width
- IMG_H, 64, bitmap height in rows
- ADDR_W, 11, ROM address width; must satisfy 2^ADDR_W >= IMG_H
- SCALE_LOG2, 0, integer upscale factor 2^SCALE_LOG2 (0..3)
- COLOR_W, 1, bits per colour channel
- BLINK_FRAMES, 30, frames per blink half-period

Ports:
- CLK_40M  in  1  pixel clock
- RSTn  in  1  asynchronous active-low reset
- enable  in  1  1 = render; 0 = colour outputs forced to 0, sync keeps running
- img_x  in  11  image left edge, pixels
- img_y  in  11  image top edge, lines
- fg_rgb  in  3*COLOR_W  foreground colour {R,G,B}, used for ROM bit = 1
- bg_rgb  in  3*COLOR_W  background colour, used for ROM bit = 0 and outside the image
- blink_en  in  1  enables blinking
- rom_addr  out  ADDR_W  bitmap row address to the ROM
- rom_data  in  IMG_W  ROM row data; valid exactly 1 clock after rom_addr changes
- Hsync_sig  out  1  horizontal sync
- Vsync_sig  out  1  vertical sync
- Vga_red  out  COLOR_W  red channel
- Vga_green  out  COLOR_W  green channel
- Vga_blue  out  COLOR_W  blue channel
- frame_start  out  1  one-clock pulse when h_cnt = 0 and v_cnt = 0
- blink_phase  out  1  current blink phase

Behaviour:
- Reset (async assert, sync release):
  - h_cnt = 0, v_cnt = 0, frame counter = 0.
  - All pipeline registers cleared.
  - Colour outputs = 0; Hsync_sig/Vsync_sig = ~SYNC_POL; rom_addr = 0; frame_start = 0; blink_phase = 0.
- Counters:
  - h_cnt wraps at H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP (1056).
  - v_cnt increments on h_cnt wrap and wraps at V_TOT (628).
  - Region order: active [0, H_ACTIVE), then FP, then sync, then BP; same order vertically.
  - Sync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vertical is analogous on v_cnt.
- Position latch:
  - img_x/img_y are sampled into shadow registers at h_cnt = 0, v_cnt = 0.
  - Mid-frame changes take effect on the next frame.
- Window test:
  - Computed at 12 bits to avoid overflow.
  - in_x = h_cnt >= X && h_cnt < X + (IMG_W << SCALE_LOG2) && h_cnt < H_ACTIVE; in_y is analogous with IMG_H and V_ACTIVE.
  - Portions beyond the active area are clipped; there is no wrap-around.
- Pipeline: 3 clocks from counter to pins.
  - S1: rom_addr <= (v_cnt - Y) >> SCALE_LOG2 when in_y, else holds its value. Column index c = (h_cnt - X) >> SCALE_LOG2, plus the in_x, in_y and active flags, are registered.
  - S2: rom_data valid; pixel bit = rom_data[IMG_W-1-c] (MSB is the leftmost pixel). Flags delayed one more stage.
  - S3: colour and sync output registers.
  - Hsync_sig, Vsync_sig and frame_start are delayed through the same 3 stages so they stay aligned with pixels.
- Colour select at S3, in priority order:
  1. Not active, or enable = 0 → 0.
  2. in_x && in_y && bit = 1 && !(blink_en && blink_phase) → fg_rgb.
  3. Otherwise → bg_rgb.
- Blink:
  - The frame counter increments at each frame start.
  - On reaching BLINK_FRAMES-1 it resets to 0 and toggles blink_phase.
  - The counter runs regardless of blink_en.
  - blink_en = 0 has no visual effect, but blink_phase keeps toggling.
- Simultaneous events: frame wrap and position latch occur on the same clock; the new position is used for line 0.
- Reset mid-frame: all outputs take their reset values immediately, and timing restarts at (0,0) after release.

Test Plan:
- Default params, 2 frames after reset → Hsync_sig high for 128 clocks every 1056; Vsync_sig high for 4 lines every 628; frame_start period 663168 clocks; outputs lag the counters by 3.
- ROM row 0 = 256'h8000…0001, img_x = 100, img_y = 50, fg = 3'b111, bg = 3'b000 → line 50 shows white at pixels 100 and 355 and black elsewhere; rom_addr = 0 during line 50.
- SCALE_LOG2 = 1, same ROM → pixels 100-101 and 610-611 white; each ROM row is used for 2 lines (lines 50-51 both read addr 0).
- img_x = 700 → image clipped at pixel 799; pixels 0-99 of the same line are bg, with no wrap.
- blink_en = 1, BLINK_FRAMES = 2 → image visible in frames 0-1, fg suppressed in frames 2-3, visible again in frames 4-5.
- img_x changed at v_cnt = 300 → current frame unchanged; next frame uses the new position. RSTn pulsed mid-line → colours 0 and sync inactive within the same clock; the first frame_start occurs 3 clocks after release.
